// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the 8-bit accumulator CPU.
// Parses frames (A5, ADDR_HI, ADDR_LO, LEN, data..., CSUM), writes the payload
// through a registered single-port write channel, and holds the CPU in reset
// until a run command (5A) arrives in IDLE.
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic        memWriteEnable,
  output logic [15:0] memAddress,
  output logic [7:0]  memData,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;

  localparam logic [7:0] HDR_LOAD = 8'hA5;
  localparam logic [7:0] CMD_RUN  = 8'h5A;

  logic [2:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  sum_q, sum_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        in_rst_q;

  logic        xfer;
  logic [7:0]  sum_next;

  assign inReady  = ~in_rst_q;
  assign xfer     = inValid & inReady;
  assign sum_next = sum_q + inData;

  assign memWriteEnable = we_q;
  assign memAddress     = addr_q;
  assign memData        = data_q;
  assign cpuHold        = hold_q;
  assign loadDone       = done_q;
  assign loadError      = err_q;

  // Frame parser: next-state, pointer, count, checksum and output strobes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          if (inData == HDR_LOAD) begin
            state_d = ST_ADDR_HI;
            hold_d  = 1'b1;
            sum_d   = '0;
          end else if (inData == CMD_RUN) begin
            hold_d  = 1'b0;
          end
        end
        ST_ADDR_HI: begin
          ptr_d[15:8] = inData;
          sum_d       = sum_next;
          state_d     = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          ptr_d[7:0] = inData;
          sum_d      = sum_next;
          state_d    = ST_LEN;
        end
        ST_LEN: begin
          rem_d   = (inData == 8'h00) ? 9'd256 : {1'b0, inData};
          sum_d   = sum_next;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          data_d  = inData;
          ptr_d   = ptr_q + 16'd1;
          rem_d   = rem_q - 9'd1;
          sum_d   = sum_next;
          if (rem_q == 9'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          sum_d   = sum_next;
          done_d  = (sum_next == 8'h00);
          err_d   = (sum_next != 8'h00);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons the frame and drops pending strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      in_rst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      sum_q    <= sum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      in_rst_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with hand-computed expected values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  inData = 8'h00;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        memWriteEnable;
  logic [15:0] memAddress;
  logic [7:0]  memData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned strobes  = 0;

  prog_loader dut (
    .clk            (clk),
    .reset          (reset),
    .inData         (inData),
    .inValid        (inValid),
    .inReady        (inReady),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memData        (memData),
    .cpuHold        (cpuHold),
    .loadDone       (loadDone),
    .loadError      (loadError)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Transfer one byte on the next rising edge; returns #1 after that edge.
  task automatic send(input logic [7:0] b);
    inData  = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("no_strobe_idle", {31'd0, memWriteEnable}, 32'd0);
    end
  endtask

  task automatic check_write(input string tag, input logic [15:0] a, input logic [7:0] d);
    check({tag, "_we"}, {31'd0, memWriteEnable}, 32'd1);
    check({tag, "_addr"}, {16'd0, memAddress}, {16'd0, a});
    check({tag, "_data"}, {24'd0, memData}, {24'd0, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, inReady}, 32'd1);
  endtask

  // Frame A5 01 00 03 11 22 33 csum with optional idle gap after each byte.
  task automatic frame_0100(input logic [7:0] csum, input int unsigned gap);
    send(8'hA5);
    check("hold_after_a5", {31'd0, cpuHold}, 32'd1);
    idle_cycles(gap);
    send(8'h01); idle_cycles(gap);
    send(8'h00); idle_cycles(gap);
    send(8'h03); idle_cycles(gap);
    send(8'h11); check_write("w0", 16'h0100, 8'h11); idle_cycles(gap);
    send(8'h22); check_write("w1", 16'h0101, 8'h22); idle_cycles(gap);
    send(8'h33); check_write("w2", 16'h0102, 8'h33); idle_cycles(gap);
    send(csum);
    check("csum_we", {31'd0, memWriteEnable}, 32'd0);
    check("done", {31'd0, loadDone}, {31'd0, csum == 8'h96});
    check("error", {31'd0, loadError}, {31'd0, csum != 8'h96});
    check("hold_after_csum", {31'd0, cpuHold}, 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'd0, loadDone}, 32'd0);
    check("error_one_cycle", {31'd0, loadError}, 32'd0);
  endtask

  initial begin
    // Reset values, asserted asynchronously.
    #1 reset = 1'b1;
    #1;
    check("rst_ready", {31'd0, inReady}, 32'd0);
    check("rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("rst_addr", {16'd0, memAddress}, 32'd0);
    check("rst_data", {24'd0, memData}, 32'd0);
    check("rst_hold", {31'd0, cpuHold}, 32'd1);
    check("rst_done", {31'd0, loadDone}, 32'd0);
    check("rst_err", {31'd0, loadError}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_out_of_reset", {31'd0, inReady}, 32'd1);

    // Good frame, then the same frame with a bad checksum.
    frame_0100(8'h96, 0);
    frame_0100(8'h97, 0);

    // Run and reload.
    do_reset();
    send(8'h5A);
    check("run_hold", {31'd0, cpuHold}, 32'd0);
    send(8'h00);
    check("stray00_we", {31'd0, memWriteEnable}, 32'd0);
    check("stray00_hold", {31'd0, cpuHold}, 32'd0);
    send(8'hFF);
    check("strayff_we", {31'd0, memWriteEnable}, 32'd0);
    check("strayff_hold", {31'd0, cpuHold}, 32'd0);
    // Still in IDLE: a full good frame now loads normally.
    frame_0100(8'h96, 0);

    // LEN=0 (256 bytes) with address wrap; sum FF+FF+00+(1..255)=0x7E -> CSUM 0x82.
    send(8'hA5);
    send(8'hFF);
    send(8'hFF);
    send(8'h00);
    strobes = 0;
    for (int unsigned i = 1; i <= 256; i++) begin
      send(8'(i));
      if (memWriteEnable) strobes++;
      if (i == 1) check_write("wrap_first", 16'hFFFF, 8'h01);
      if (i == 2) check_write("wrap_second", 16'h0000, 8'h02);
      if (i == 256) check_write("wrap_last", 16'h00FE, 8'h00);
    end
    check("wrap_strobes", strobes, 32'd256);
    send(8'h82);
    check("wrap_we_end", {31'd0, memWriteEnable}, 32'd0);
    check("wrap_done", {31'd0, loadDone}, 32'd1);
    check("wrap_err", {31'd0, loadError}, 32'd0);

    // Gapped stream.
    frame_0100(8'h96, 3);

    // Reset mid-frame after the second data byte.
    send(8'hA5);
    send(8'h00);
    send(8'h10);
    send(8'h04);
    send(8'hAA);
    check_write("mid_w0", 16'h0010, 8'hAA);
    send(8'hBB);
    check_write("mid_w1", 16'h0011, 8'hBB);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("mid_rst_addr", {16'd0, memAddress}, 32'd0);
    check("mid_rst_data", {24'd0, memData}, 32'd0);
    check("mid_rst_hold", {31'd0, cpuHold}, 32'd1);
    check("mid_rst_ready", {31'd0, inReady}, 32'd0);
    check("mid_rst_done", {31'd0, loadDone}, 32'd0);
    check("mid_rst_err", {31'd0, loadError}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    frame_0100(8'h96, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 8-bit accumulator CPU. It receives framed load commands on a valid/ready byte interface and writes the payload into CPU memory through a one-port write channel. It holds the CPU in reset while loading and releases it on a run command. It is the writer side of the memory the CPU fetches from, and sits between the host link and the CPU top plus memory.

## Interface
- No parameters. Data is 8 bits, address is 16 bits, frame header values are fixed constants.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- inData  in  8  stream byte from host.
- inValid  in  1  inData valid.
- inReady  out  1  loader can accept a byte; a byte transfers when inValid && inReady on a rising clk edge.
- memWriteEnable  out  1  one-cycle memory write strobe.
- memAddress  out  16  write address.
- memData  out  8  write data.
- cpuHold  out  1  high = CPU held in reset. Drives the CPU reset input, ORed with system reset outside this block.
- loadDone  out  1  one-cycle pulse: frame finished with a good checksum.
- loadError  out  1  one-cycle pulse: frame finished with a bad checksum.

## Operation
- Frame: 0xA5, ADDR_HI, ADDR_LO, LEN, LEN' data bytes, CSUM.
  - LEN' = LEN, except LEN = 0x00 means 256.
  - CSUM is chosen so the 8-bit sum of ADDR_HI + ADDR_LO + LEN + all data bytes + CSUM is 0x00 (mod 256).
- Run command: single byte 0x5A received in IDLE.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM. Each state advances only on a byte transfer.
- IDLE:
  - 0xA5 → ADDR_HI. Sets cpuHold, clears the running sum.
  - 0x5A → stay in IDLE. Clears cpuHold.
  - Any other byte is consumed and ignored.
- ADDR_HI / ADDR_LO: latch the address pointer bytes, add each to the sum.
- LEN: latch the 9-bit remaining count (0 → 256), add the byte to the sum, → DATA.
- DATA, on each byte:
  - Register memData = byte and memAddress = pointer; pulse memWriteEnable.
  - Pointer += 1, wrapping 0xFFFF → 0x0000.
  - Remaining -= 1; add the byte to the sum.
  - When remaining reaches 0, → CSUM.
- CSUM: add the byte to the sum.
  - Sum == 0x00 → pulse loadDone, else pulse loadError.
  - → IDLE either way. cpuHold stays high in both cases.
- Data is written before the checksum is checked. On error, memory holds whatever was written; the host must reload.
- inReady is 1 in every state while reset is low. The loader never stalls the stream.
- Reset mid-frame: the in-progress frame is abandoned, any pending write strobe is dropped, and the FSM returns to IDLE. Memory already written is untouched.

## Timing
- Reset values:
  - state = IDLE, inReady = 0 while reset is high.
  - memWriteEnable = 0, memAddress = 0x0000, memData = 0x00.
  - cpuHold = 1, loadDone = 0, loadError = 0.
- Write latency: memWriteEnable/memAddress/memData are registered. The strobe is high for exactly the one cycle after the data-byte transfer edge. Address and data hold their values until the next write.
- Back-to-back data bytes produce back-to-back single-cycle strobes (one write per clk); there is no gap.
- loadDone / loadError go high the cycle after the CSUM transfer, for one cycle. They are mutually exclusive.
- cpuHold:
  - Falls the cycle after the 0x5A transfer.
  - Rises the cycle after the 0xA5 transfer.
  - Changes only on those two events.
- Max throughput is one byte per clk. Frame cost is 5 + LEN' cycles.
- All outputs are glitch-free registers except inReady, which is the inverse of the registered reset-state flag.

## Test plan
- Good frame: A5 01 00 03 11 22 33, CSUM = 0x100 − (0x01+0x00+0x03+0x11+0x22+0x33 = 0x6A) = 0x96, sent on consecutive clks.
  - Writes 0x0100=0x11, 0x0101=0x22, 0x0102=0x33 on three consecutive cycles.
  - loadDone pulses once; cpuHold stays 1.
- Bad checksum: same frame with CSUM 0x97.
  - Same three writes occur.
  - loadError pulses once; loadDone stays 0.
- Run and reload:
  - After reset, send 5A → cpuHold 1→0 the next cycle.
  - Then send A5 → cpuHold returns to 1.
  - Stray bytes 0x00 and 0xFF in IDLE produce no writes and no state change.
- Wrap and LEN=0:
  - A5 FF FF 00 followed by 256 bytes 0x01..0x00.
  - First write at 0xFFFF, second at 0x0000, last at 0x00FE; exactly 256 strobes.
  - Correct CSUM → loadDone.
- Gapped stream: good frame with inValid deasserted for 3 cycles between bytes → identical writes and loadDone. No strobe on idle cycles.
- Reset mid-frame: assert reset after the second data byte of A5 00 10 04 ….
  - All outputs return to reset values asynchronously.
  - A subsequent good frame loads correctly.
